fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 24 ++
 rtl/fetch_skid_buffer.sv | 32 +++
 rtl/fetch_stage.sv | 103 ++++++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
// ============================================================================
// fetch_stage_pkg : shared MIPS front-end constants and fetch FSM encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package fetch_stage_pkg;

  localparam logic [31:0] MIPS_RESET_PC  = 32'h0040_0000;
  localparam logic [31:0] MIPS_NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_REQ   = 2'd0,
    FETCH_HELD  = 2'd1,
    FETCH_DRAIN = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_skid_buffer.sv
// ============================================================================
// fetch_skid_buffer : one-word holding register for a fetch returned under stall
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_skid_buffer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] load_data,
  output logic [31:0] data,
  output logic        full
);

  // clear wins so a redirect in the same cycle never leaves a stale word behind
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
      full <= 1'b0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      data <= load_data;
      full <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// fetch_stage : MIPS instruction fetch with IF/ID register, stall skid and redirect drain
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = MIPS_RESET_PC,
  parameter logic [31:0] NOP_INSTR = MIPS_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr_out,
  output logic [31:0] pc_plus4_out,
  output logic        instr_valid
);

  fetch_state_e state;
  logic [31:0]  pc;
  logic [31:0]  pc_next4;
  logic         skid_load;
  logic         skid_clear;
  logic         skid_full;
  logic [31:0]  skid_data;

  assign pc_next4   = pc + 32'd4;
  assign imem_addr  = pc;
  assign imem_req   = (state != FETCH_HELD);
  assign skid_load  = (state == FETCH_REQ) && imem_ready && stall && !redirect_valid;
  assign skid_clear = redirect_valid || ((state == FETCH_HELD) && !stall);

  fetch_skid_buffer u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (skid_load),
    .clear     (skid_clear),
    .load_data (imem_rdata),
    .data      (skid_data),
    .full      (skid_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= FETCH_REQ;
      pc           <= word_align(RESET_PC);
      instr_out    <= NOP_INSTR;
      pc_plus4_out <= '0;
      instr_valid  <= 1'b0;
    end else if (redirect_valid) begin
      // an unanswered request must be drained before the new target is fetched
      pc          <= word_align(redirect_pc);
      instr_out   <= NOP_INSTR;
      instr_valid <= 1'b0;
      if ((state == FETCH_DRAIN) || ((state == FETCH_REQ) && !imem_ready))
        state <= FETCH_DRAIN;
      else
        state <= FETCH_REQ;
    end else begin
      case (state)
        FETCH_REQ: begin
          if (!stall) begin
            if (imem_ready) begin
              instr_out    <= imem_rdata;
              pc_plus4_out <= pc_next4;
              instr_valid  <= 1'b1;
              pc           <= pc_next4;
            end else begin
              instr_out   <= NOP_INSTR;
              instr_valid <= 1'b0;
            end
          end else if (imem_ready) begin
            state <= FETCH_HELD;
          end
        end
        FETCH_HELD: begin
          if (!stall && skid_full) begin
            instr_out    <= skid_data;
            pc_plus4_out <= pc_next4;
            instr_valid  <= 1'b1;
            pc           <= pc_next4;
            state        <= FETCH_REQ;
          end
        end
        FETCH_DRAIN: begin
          if (imem_ready) state <= FETCH_REQ;
        end
        default: state <= FETCH_REQ;
      endcase
    end
  end

endmodule

`default_nettype wire
